// File: rtl/fa_pipe_nbit.sv
// Pipelined WIDTH-bit adder/subtractor. The carry chain is cut into STAGES
// chunks of WIDTH/STAGES bits, one chunk per register stage. Every stage has
// a valid bit and a valid/ready handshake, so the pipe sustains one result per
// clock and stalls cleanly under backpressure.
// WIDTH must be a multiple of STAGES, and both must be at least 1.
module fa_pipe_nbit #(
   parameter int unsigned WIDTH  = 16,
   parameter int unsigned STAGES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             co,
   output logic             ov
);

   localparam int unsigned C = WIDTH / STAGES;

   // Per-stage registers. opa/opb hold full operands; each stage only
   // consumes its own chunk, and synthesis trims the bits already summed.
   logic [STAGES-1:0]            vld_q;
   logic [STAGES-1:0][WIDTH-1:0] sum_q, sum_d;
   logic [STAGES-1:0][WIDTH-1:0] opa_q, opa_d;
   logic [STAGES-1:0][WIDTH-1:0] opb_q, opb_d;
   logic [STAGES-1:0]            cy_q, cy_d;
   logic                         ov_q, ov_d;

   // Stage k reads its inputs from index k: index 0 is the input port,
   // index k>0 is the register of stage k-1.
   logic [STAGES:0][WIDTH-1:0] src_a, src_b, src_s;
   logic [STAGES:0]            src_c, src_v;

   logic [STAGES:0]   can_load;
   logic [STAGES-1:0] adv;
   logic [STAGES-1:0] load;
   logic [C:0]        chunk;

   logic [WIDTH-1:0] b_e;
   logic             c_e;
   logic             unused_last_ops;

   // Subtract is a + ~b + ~ci, so co reads as NOT-borrow.
   assign b_e = sub ? ~b : b;
   assign c_e = sub ? ~ci : ci;

   assign src_a = {opa_q, a};
   assign src_b = {opb_q, b_e};
   assign src_s = {sum_q, {WIDTH{1'b0}}};
   assign src_c = {cy_q, c_e};
   assign src_v = {vld_q, in_valid};

   // The last stage's operand copies feed nothing downstream.
   assign unused_last_ops = ^{src_a[STAGES], src_b[STAGES]};

   // Ready chain, walked from the output back to the input.
   always_comb begin
      can_load                = '0;
      adv                     = '0;
      load                    = '0;
      can_load[STAGES]        = out_ready;
      for (int i = STAGES - 1; i >= 0; i--) begin
         adv[i]      = vld_q[i] & can_load[i+1];
         can_load[i] = ~vld_q[i] | adv[i];
         load[i]     = src_v[i] & can_load[i];
      end
   end

   // Chunk adders: each stage adds its slice plus the carry from upstream.
   always_comb begin
      sum_d = sum_q;
      cy_d  = cy_q;
      opa_d = opa_q;
      opb_d = opb_q;
      chunk = '0;
      for (int k = 0; k < STAGES; k++) begin
         chunk = {1'b0, src_a[k][k*C +: C]} + {1'b0, src_b[k][k*C +: C]}
               + {{C{1'b0}}, src_c[k]};
         sum_d[k]            = src_s[k];
         sum_d[k][k*C +: C]  = chunk[C-1:0];
         cy_d[k]             = chunk[C];
         opa_d[k]            = src_a[k];
         opb_d[k]            = src_b[k];
      end
      // Carry into the MSB is recovered as a^b^s at that bit.
      ov_d = src_a[STAGES-1][WIDTH-1] ^ src_b[STAGES-1][WIDTH-1]
           ^ sum_d[STAGES-1][WIDTH-1] ^ cy_d[STAGES-1];
   end

   // Stage registers: valid tracks load/advance; data captured on load only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= '0;
         sum_q <= '0;
         opa_q <= '0;
         opb_q <= '0;
         cy_q  <= '0;
         ov_q  <= 1'b0;
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            vld_q[k] <= load[k] | (vld_q[k] & ~adv[k]);
            if (load[k]) begin
               sum_q[k] <= sum_d[k];
               opa_q[k] <= opa_d[k];
               opb_q[k] <= opb_d[k];
               cy_q[k]  <= cy_d[k];
            end
         end
         if (load[STAGES-1]) begin
            ov_q <= ov_d;
         end
      end
   end

   assign in_ready  = can_load[0];
   assign out_valid = vld_q[STAGES-1];
   assign s         = sum_q[STAGES-1];
   assign co        = cy_q[STAGES-1];
   assign ov        = ov_q;

endmodule

// File: doc/fa_pipe_nbit.md
# fa_pipe_nbit

Parametrised, pipelined N-bit full adder/subtractor with valid/ready handshakes on both sides. It generalises the team's 4-bit combinational full adders (`s`, `co`, `a`, `b`, `ci`) to arbitrary width. The carry chain is split across `STAGES` register stages, and the block adds a subtract mode, a signed-overflow flag and full backpressure. It sits in the datapath wherever a wide add must close timing at one result per clock.

## Interface
- `WIDTH`, default 16: operand and sum width in bits. Must be ≥ 1.
- `STAGES`, default 4: pipeline depth. Must be ≥ 1, and `WIDTH % STAGES == 0`. Chunk width `C = WIDTH/STAGES`.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `in_valid`, in, 1: operands present.
- `in_ready`, out, 1: block can accept this cycle.
- `a`, in, WIDTH: operand A.
- `b`, in, WIDTH: operand B.
- `ci`, in, 1: carry-in (borrow-in when `sub=1`).
- `sub`, in, 1: 0 = add, 1 = subtract.
- `out_valid`, out, 1: result present.
- `out_ready`, in, 1: downstream accepts.
- `s`, out, WIDTH: sum/difference.
- `co`, out, 1: carry-out. When `sub=1` this is NOT-borrow.
- `ov`, out, 1: signed overflow.

## Operation
- Effective operand: `b_e = sub ? ~b : b`, `c_e = sub ? ~ci : ci`.
- Result: `{co, s} = a + b_e + c_e`, computed at WIDTH+1 bits.
  - `sub=0`: a + b + ci.
  - `sub=1`: a − b − ci.
- `ov` = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
- Stage k (0..STAGES-1):
  - Adds chunk bits `[k*C +: C]` of `a` and `b_e` plus the carry registered by stage k-1. Stage 0 uses `c_e`.
  - Registers: the partial sum so far, the chunk carry-out, the unprocessed upper operand bits, and a valid bit.
- Stage STAGES-1 registers the final `s`, `co` and `ov`. These drive the outputs directly; no combinational logic sits after the last register.
- Handshake, per stage:
  - Stage i loads when its upstream is valid and (stage i is empty, or stage i is advancing).
  - Stage i advances when it is valid and (i is last ? `out_ready` : stage i+1 can load).
  - `in_ready` = stage 0 empty OR stage 0 advancing. A combinational ready chain from `out_ready` is permitted.
- Transfer occurs only when valid and ready are both high in the same cycle. Operands and `sub` are sampled only on that edge.
- Ordering is strictly FIFO. No result is dropped or duplicated.
- While `out_valid && !out_ready`, the outputs `s`, `co` and `ov` hold stable.
- Each stage carries its own copy of `sub`-derived data, so mixed add/sub streams are legal.

## Timing
- Reset (`rst_n` low, asynchronous): all stage valid bits and data registers clear immediately.
  - `out_valid=0`, `s=0`, `co=0`, `ov=0`.
  - `in_ready=1`, since the pipe is empty, but nothing is captured while `rst_n` is low.
- Reset mid-operation: all in-flight transactions are discarded. No output appears after release unless new inputs are accepted.
- Latency: a transaction accepted on edge E has `out_valid=1` following edge E+STAGES-1. The result is therefore presented STAGES cycles after the input cycle.
- Throughput: 1 result per clock with `out_ready` held high.
- Full pipe with `out_ready=0`: all STAGES stages hold, and `in_ready=0` combinationally in the same cycle.
- Simultaneous pop and push on a full pipe: both transfers occur and occupancy is unchanged.
- `STAGES=1`: degenerates to a registered WIDTH-bit adder with a one-entry skid.
- Wrap-around: `s` is modulo 2^WIDTH. The carry beyond WIDTH appears only on `co`.

## Test plan
- Reset:
  - Stimulus: assert `rst_n=0` with any inputs.
  - Required: `out_valid=0`, `s=0x0000`, `co=0`, `ov=0`, `in_ready=1`.
  - Stimulus: release reset with `in_valid=0` for 10 cycles.
  - Required: outputs unchanged.
- Add with signed overflow (defaults):
  - Stimulus: `a=0x7FFF`, `b=0x0001`, `ci=0`, `sub=0`, single beat.
  - Required: exactly 4 cycles later `out_valid=1`, `s=0x8000`, `co=0`, `ov=1`.
- Full carry ripple across all chunks:
  - Stimulus: `a=0xFFFF`, `b=0x0000`, `ci=1`.
  - Required: `s=0x0000`, `co=1`, `ov=0`.
- Subtract with borrow:
  - Stimulus: `a=0x0005`, `b=0x0007`, `ci=0`, `sub=1`.
  - Required: `s=0xFFFE`, `co=0`, `ov=0`.
  - Stimulus: same but `ci=1`.
  - Required: `s=0xFFFD`.
- Backpressure:
  - Stimulus: stream 20 random beats with `in_valid` always high; hold `out_ready=0` for 6 cycles mid-stream.
  - Required: `in_ready` falls once 4 stages are full; outputs hold stable while stalled; all 20 results match the reference model in order, with no loss or duplication.
- Reset mid-stream and minimum config:
  - Stimulus: pulse `rst_n` low asynchronously with 3 beats in flight.
  - Required: `out_valid` drops without waiting for a clock edge; no stale result appears afterwards.
  - Stimulus: instance `WIDTH=4`, `STAGES=1`, run 8 random `{ci,a,b}` vectors.
  - Required: results match 4-bit full-adder truth after 1 cycle.
